// File: rtl/pipe_sum_pkg.sv
// rtl/pipe_sum_pkg.sv - shared defaults, op encoding and the chunk adder for pipe_sum
package pipe_sum_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;
  localparam int MAX_CHUNK      = 64;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Bits of a and b at or above w are masked off; cout is the carry out of bit w-1.
  function automatic logic [MAX_CHUNK:0] chunk_add(
    input logic [MAX_CHUNK-1:0] a,
    input logic [MAX_CHUNK-1:0] b,
    input logic                 cin,
    input int                   w
  );
    logic [MAX_CHUNK:0]   full;
    logic [MAX_CHUNK-1:0] mask;
    mask = (w >= MAX_CHUNK) ? '1 : ((MAX_CHUNK'(1) << w) - MAX_CHUNK'(1));
    full = {1'b0, a & mask} + {1'b0, b & mask} + {{MAX_CHUNK{1'b0}}, cin};
    chunk_add = {full[w], full[MAX_CHUNK-1:0] & mask};
  endfunction

endpackage

// File: rtl/pipe_sum_stage.sv
// rtl/pipe_sum_stage.sv - one skewed-pipeline stage: adds chunk IDX and keeps only the bits still needed
module pipe_sum_stage
  import pipe_sum_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_WIDTH / DEFAULT_STAGES,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             adv_next,
  output logic             adv,
  output logic             valid_q,
  input  logic             cin,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  output logic             cout_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] sum_q,
  output logic [1:0]       sign_q
);

  localparam int LO      = IDX * CHUNK;
  localparam int HI_DONE = LO + CHUNK;

  logic [MAX_CHUNK:0]   r;
  logic [WIDTH-1:0]     sum_nxt;
  logic [HI_DONE-1:0]   sum_r;
  logic                 load;
  logic                 unused_bits;

  assign adv  = !valid_q || adv_next;
  assign load = adv && valid_in;

  always_comb begin
    r = chunk_add(MAX_CHUNK'(a_in[LO +: CHUNK]), MAX_CHUNK'(b_in[LO +: CHUNK]), cin, CHUNK);
    sum_nxt = sum_in;
    sum_nxt[LO +: CHUNK] = r[CHUNK-1:0];
  end

  // Only this stage's consumed operand bits and the unfinished sum bits are dropped.
  assign unused_bits = ^{a_in, b_in, sum_in, r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      cout_q  <= 1'b0;
      sum_r   <= '0;
      sign_q  <= 2'b00;
    end else if (adv) begin
      valid_q <= valid_in;
      if (valid_in) begin
        cout_q <= r[MAX_CHUNK];
        sum_r  <= sum_nxt[HI_DONE-1:0];
        sign_q <= {a_in[WIDTH-1], b_in[WIDTH-1]};
      end
    end
  end

  assign sum_q = WIDTH'(sum_r);

  if (HI_DONE < WIDTH) begin : g_rem
    logic [WIDTH-1:HI_DONE] a_rem_r, b_rem_r;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_rem_r <= '0;
        b_rem_r <= '0;
      end else if (load) begin
        a_rem_r <= a_in[WIDTH-1:HI_DONE];
        b_rem_r <= b_in[WIDTH-1:HI_DONE];
      end
    end
    assign a_q = {a_rem_r, {HI_DONE{1'b0}}};
    assign b_q = {b_rem_r, {HI_DONE{1'b0}}};
  end else begin : g_top
    assign a_q = '0;
    assign b_q = '0;
  end

endmodule

// File: rtl/pipe_sum.sv
// rtl/pipe_sum.sv - pipelined add/subtract, one CHUNK-bit ripple per stage, bubble-collapsing flow control
module pipe_sum
  import pipe_sum_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0 || CHUNK > MAX_CHUNK)
  begin : g_bad_params
    $error("pipe_sum: illegal WIDTH/STAGES combination");
  end

  op_e              op;
  logic [WIDTH-1:0] a_w     [STAGES+1];
  logic [WIDTH-1:0] b_w     [STAGES+1];
  logic [WIDTH-1:0] sum_w   [STAGES+1];
  logic             carry_w [STAGES+1];
  logic             valid_w [STAGES+1];
  logic             adv_w   [STAGES+1];
  logic [1:0]       sign_w  [STAGES];

  assign op         = op_e'(in_sub);
  assign a_w[0]     = in_a;
  assign b_w[0]     = (op == OP_SUB) ? ~in_b : in_b;
  assign sum_w[0]   = '0;
  assign carry_w[0] = (op == OP_SUB) ? 1'b1 : in_cin;
  assign valid_w[0] = in_valid;
  assign adv_w[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_sum_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_in (valid_w[k]),
      .adv_next (adv_w[k+1]),
      .adv      (adv_w[k]),
      .valid_q  (valid_w[k+1]),
      .cin      (carry_w[k]),
      .a_in     (a_w[k]),
      .b_in     (b_w[k]),
      .sum_in   (sum_w[k]),
      .cout_q   (carry_w[k+1]),
      .a_q      (a_w[k+1]),
      .b_q      (b_w[k+1]),
      .sum_q    (sum_w[k+1]),
      .sign_q   (sign_w[k])
    );
  end

  assign in_ready  = adv_w[0];
  assign out_valid = valid_w[STAGES];
  assign out_sum   = sum_w[STAGES];
  assign out_cout  = carry_w[STAGES];
  // sign_w holds {A msb, B_eff msb} as seen by the top chunk.
  assign out_ovf   = (sign_w[STAGES-1][1] == sign_w[STAGES-1][0]) &&
                     (out_sum[WIDTH-1] != sign_w[STAGES-1][1]);

endmodule
